// File: rtl/inv_shiftrows_stream.sv
// -----------------------------------------------------------------------------
// inv_shiftrows_stream
//
// Byte-serial AES (Inv)ShiftRows permutation buffer. A 128-bit state arrives
// one byte per transfer in column-major order (k = row + 4*col). It is written
// into one of two 16-byte ping-pong banks. Once a bank is complete it is read
// back in the same k order, but each output byte is fetched from the permuted
// source index. That gives one byte per clock with no bubbles between states.
//
// Handshake (both ports): a byte moves on a rising edge where valid & ready
// are both high. A producer holds valid and data stable until that happens.
// in_ready comes only from registered flags, so it has no combinational path
// from out_ready. out_valid/out_data/out_last stay stable while out_ready is
// low.
//
// Parameters:
//   INVERSE        1: InvShiftRows  out[r][c] = in[r][(c - r) mod 4]
//                  0: ShiftRows     out[r][c] = in[r][(c + r) mod 4]
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   flush          synchronous clear, same effect as reset, wins over handshakes
//   in_valid/in_ready/in_data      byte input stream
//   out_valid/out_ready/out_data   permuted byte output stream
//   out_last       marks the 16th output byte of a state
//   busy           a bank is full or a state is partially written
//   dbg_bank_state per-bank lifecycle {bank1, bank0}:
//                  0 EMPTY, 1 FILLING, 2 FULL, 3 DRAINING
// -----------------------------------------------------------------------------
module inv_shiftrows_stream #(
  parameter bit INVERSE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic [3:0] dbg_bank_state
);

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // Storage: two ping-pong banks, indexed by input byte position k.
  logic [7:0] r_bank0 [16];
  logic [7:0] r_bank1 [16];

  // Control state.
  logic [1:0] r_full;
  logic       r_wbank;
  logic       r_rbank;
  logic [3:0] r_wcnt;
  logic [3:0] r_rcnt;

  // Next-state values.
  logic [1:0] w_full_nxt;
  logic       w_wbank_nxt;
  logic       w_rbank_nxt;
  logic [3:0] w_wcnt_nxt;
  logic [3:0] w_rcnt_nxt;

  logic       w_wr_fire;
  logic       w_rd_fire;

  // Read address generation.
  logic [1:0] w_row;
  logic [1:0] w_col;
  logic [1:0] w_src_col;
  logic [3:0] w_src;

  bank_state_e w_bank_state [2];

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  assign in_ready  = ~r_full[r_wbank];
  assign out_valid = r_full[r_rbank];
  assign w_wr_fire = in_valid & in_ready;
  assign w_rd_fire = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Source index for the current output position. The column arithmetic is
  // two bits wide, so the mod-4 wrap comes for free.
  // ---------------------------------------------------------------------------
  assign w_row     = r_rcnt[1:0];
  assign w_col     = r_rcnt[3:2];
  assign w_src_col = INVERSE ? (w_col - w_row) : (w_col + w_row);
  assign w_src     = {w_src_col, w_row};

  assign out_data  = r_rbank ? r_bank1[w_src] : r_bank0[w_src];
  assign out_last  = out_valid & (r_rcnt == 4'd15);
  assign busy      = r_full[0] | r_full[1] | (r_wcnt != 4'd0);

  // ---------------------------------------------------------------------------
  // Bank storage. The contents are not reset: a bank is only read after it has
  // been completely rewritten.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      if (r_wbank) begin
        r_bank1[r_wcnt] <= in_data;
      end else begin
        r_bank0[r_wcnt] <= in_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control next-state logic. The write and read sides always work on
  // different banks: writing needs ~full and reading needs full. So a final
  // write and a final read in the same cycle touch two distinct flag bits.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_full_nxt  = r_full;
    w_wbank_nxt = r_wbank;
    w_rbank_nxt = r_rbank;
    w_wcnt_nxt  = r_wcnt;
    w_rcnt_nxt  = r_rcnt;

    if (flush) begin
      w_full_nxt  = 2'b00;
      w_wbank_nxt = 1'b0;
      w_rbank_nxt = 1'b0;
      w_wcnt_nxt  = 4'd0;
      w_rcnt_nxt  = 4'd0;
    end else begin
      if (w_wr_fire) begin
        w_wcnt_nxt = r_wcnt + 4'd1;
        if (r_wcnt == 4'd15) begin
          w_full_nxt[r_wbank] = 1'b1;
          w_wbank_nxt         = ~r_wbank;
        end
      end
      if (w_rd_fire) begin
        w_rcnt_nxt = r_rcnt + 4'd1;
        if (r_rcnt == 4'd15) begin
          w_full_nxt[r_rbank] = 1'b0;
          w_rbank_nxt         = ~r_rbank;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 2'b00;
      r_wbank <= 1'b0;
      r_rbank <= 1'b0;
      r_wcnt  <= 4'd0;
      r_rcnt  <= 4'd0;
    end else begin
      r_full  <= w_full_nxt;
      r_wbank <= w_wbank_nxt;
      r_rbank <= w_rbank_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bank lifecycle, decoded from the flags and pointers:
  // EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_bank_state[b] = BANK_EMPTY;
      if (r_full[b]) begin
        if ((r_rbank == b[0]) && (r_rcnt != 4'd0)) begin
          w_bank_state[b] = BANK_DRAINING;
        end else begin
          w_bank_state[b] = BANK_FULL;
        end
      end else if ((r_wbank == b[0]) && (r_wcnt != 4'd0)) begin
        w_bank_state[b] = BANK_FILLING;
      end
    end
  end

  assign dbg_bank_state = {w_bank_state[1], w_bank_state[0]};

endmodule

// File: tb/tb_inv_shiftrows_stream.sv
// -----------------------------------------------------------------------------
// Bench for inv_shiftrows_stream. An inverse instance and a forward instance
// share the same input and out_ready streams. A negedge monitor feeds accepted
// bytes into a row/column reference model and pops expected output bytes from
// per-instance queues.
// -----------------------------------------------------------------------------
module tb_inv_shiftrows_stream;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready,  fwd_in_ready;
  logic       out_valid, fwd_out_valid;
  logic [7:0] out_data,  fwd_out_data;
  logic       out_last,  fwd_out_last;
  logic       busy,      fwd_busy;
  logic [3:0] dbg,       fwd_dbg;

  inv_shiftrows_stream #(.INVERSE(1'b1)) u_dut_inv (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .dbg_bank_state(dbg)
  );

  inv_shiftrows_stream #(.INVERSE(1'b0)) u_dut_fwd (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(fwd_in_ready), .in_data(in_data),
    .out_valid(fwd_out_valid), .out_ready(out_ready), .out_data(fwd_out_data),
    .out_last(fwd_out_last), .busy(fwd_busy), .dbg_bank_state(fwd_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] part_q[$];
  logic [7:0] exp_inv_q[$];
  logic [7:0] exp_fwd_q[$];
  logic [7:0] log_inv_q[$];
  logic [7:0] log_fwd_q[$];
  int         out_cyc_q[$];
  int         cyc = 0;
  int         inv_idx = 0;
  int         fwd_idx = 0;
  int         in_stalls = 0;
  int         rdy_mode = 0;   // 0: out_ready low, 1: high, 2: random
  bit         gap_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference permutation straight from the row/column definition.
  function automatic void permute(input logic [7:0] st[16], input bit inv,
                                  output logic [7:0] res[16]);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int sc;
        sc = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        res[r + 4 * c] = st[r + 4 * sc];
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: samples at negedge, while inputs driven at posedge+1 are stable
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [7:0] st [16];
    logic [7:0] ri [16];
    logic [7:0] rf [16];
    cyc++;
    if (!rst_n || flush) begin
      part_q.delete();
      exp_inv_q.delete();
      exp_fwd_q.delete();
      inv_idx = 0;
      fwd_idx = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_inv_q.size() == 0) begin
          check_eq("inv_unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check_eq("inv_out_data", 32'(out_data), 32'(exp_inv_q.pop_front()));
          check_eq("inv_out_last", 32'(out_last), 32'(inv_idx == 15));
        end
        log_inv_q.push_back(out_data);
        out_cyc_q.push_back(cyc);
        inv_idx = (inv_idx + 1) % 16;
      end
      if (fwd_out_valid && out_ready) begin
        if (exp_fwd_q.size() == 0) begin
          check_eq("fwd_unexpected_out", 32'(fwd_out_data), 32'hFFFF_FFFF);
        end else begin
          check_eq("fwd_out_data", 32'(fwd_out_data), 32'(exp_fwd_q.pop_front()));
          check_eq("fwd_out_last", 32'(fwd_out_last), 32'(fwd_idx == 15));
        end
        log_fwd_q.push_back(fwd_out_data);
        fwd_idx = (fwd_idx + 1) % 16;
      end
      if (in_valid && in_ready) begin
        part_q.push_back(in_data);
        if (part_q.size() == 16) begin
          for (int i = 0; i < 16; i++) st[i] = part_q[i];
          permute(st, 1'b1, ri);
          permute(st, 1'b0, rf);
          for (int i = 0; i < 16; i++) begin
            exp_inv_q.push_back(ri[i]);
            exp_fwd_q.push_back(rf[i]);
          end
          part_q.delete();
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_byte(input logic [7:0] b);
    int  guard;
    bit  done;
    guard = 0;
    done  = 1'b0;
    if (gap_en) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
      end else begin
        in_stalls++;
        guard++;
        if (guard > 2000) begin
          check_eq("in_accept_timeout", 32'(guard), 32'd0);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) push_byte(8'($urandom));
  endtask

  task automatic wait_drain(input string tag);
    int  guard;
    bit  done;
    guard = 0;
    done  = 1'b0;
    rdy_mode = 1;
    while (!done) begin
      @(negedge clk);
      guard++;
      if (exp_inv_q.size() == 0 && exp_fwd_q.size() == 0 && part_q.size() == 0 && !busy)
        done = 1'b1;
      else if (guard > 3000) begin
        check_eq({tag, "_drain_timeout"}, 32'(exp_inv_q.size()), 32'd0);
        done = 1'b1;
      end
    end
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_out_last"}, 32'(out_last), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_dbg"}, 32'(dbg), 32'd0);
    check_eq({tag, "_fwd_busy"}, 32'(fwd_busy), 32'd0);
    check_eq({tag, "_fwd_dbg"}, 32'(fwd_dbg), 32'd0);
    check_eq({tag, "_fwd_out_valid"}, 32'(fwd_out_valid), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [7:0] tab_inv [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                               8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
  logic [7:0] tab_fwd [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                               8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};

  initial begin
    int guard;
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_release");
    @(posedge clk);
    #1;

    // Directed state 0x00..0x0F, both permutations, latency and out_last
    rdy_mode = 1;
    log_inv_q.delete();
    log_fwd_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check_eq("lat_pre_valid", 32'(out_valid), 32'd0);
      push_byte(8'(i));
    end
    check_eq("lat_valid_after_16th", 32'(out_valid), 32'd1);
    check_eq("lat_fwd_valid_after_16th", 32'(fwd_out_valid), 32'd1);
    wait_drain("dir");
    check_eq("dir_log_inv_size", 32'(log_inv_q.size()), 32'd16);
    check_eq("dir_log_fwd_size", 32'(log_fwd_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < log_inv_q.size()) check_eq($sformatf("dir_inv_tab%0d", i), 32'(log_inv_q[i]), 32'(tab_inv[i]));
      if (i < log_fwd_q.size()) check_eq($sformatf("dir_fwd_tab%0d", i), 32'(log_fwd_q[i]), 32'(tab_fwd[i]));
    end

    // Three back-to-back states at full rate
    in_stalls = 0;
    out_cyc_q.delete();
    push_random(48);
    wait_drain("b2b");
    check_eq("b2b_in_stalls", 32'(in_stalls), 32'd0);
    check_eq("b2b_out_count", 32'(out_cyc_q.size()), 32'd48);
    if (out_cyc_q.size() == 48)
      check_eq("b2b_contiguous", 32'(out_cyc_q[47] - out_cyc_q[0]), 32'd47);

    // Backpressure: both banks fill, then drain one and see in_ready return
    rdy_mode = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    in_stalls = 0;
    push_random(32);
    check_eq("bp_in_stalls", 32'(in_stalls), 32'd0);
    @(negedge clk);
    check_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
    check_eq("bp_busy", 32'(busy), 32'd1);
    check_eq("bp_dbg_both_full", 32'(dbg), 32'hA);
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_stall_valid", 32'(out_valid), 32'd1);
      check_eq("bp_stall_data", 32'(out_data), 32'(exp_inv_q[0]));
      check_eq("bp_stall_fwd_data", 32'(fwd_out_data), 32'(exp_fwd_q[0]));
      check_eq("bp_stall_last", 32'(out_last), 32'd0);
      @(negedge clk);
    end
    rdy_mode = 1;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_eq($sformatf("bp_drain%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    check_eq("bp_in_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    wait_drain("bp");

    // Reset mid-state after 7 bytes
    push_random(7);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_random(16);
    wait_drain("after_rst");

    // Flush while draining
    rdy_mode = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    push_random(32);
    rdy_mode = 1;
    guard = 0;
    while (inv_idx < 5 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("flush_reached_drain", 32'(guard < 200), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check_reset_outputs("flush");
    @(posedge clk);
    #1;
    push_random(16);
    wait_drain("after_flush");

    // Random valid/ready traffic over 100 states
    gap_en   = 1'b1;
    rdy_mode = 2;
    log_inv_q.delete();
    push_random(1600);
    gap_en = 1'b0;
    wait_drain("rand");
    check_eq("rand_out_count", 32'(log_inv_q.size()), 32'd1600);
    check_eq("rand_exp_left", 32'(exp_inv_q.size() + exp_fwd_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inv_shiftrows_stream.md
# inv_shiftrows_stream

Byte-serial AES (Inv)ShiftRows permutation buffer for the decryption datapath. It accepts 128-bit AES states one byte per transfer in FIPS-197 column-major order and emits the same state, permuted, one byte per transfer. Two 16-byte ping-pong banks sustain one byte per clock. It sits between the byte-serial AddRoundKey stage and the InvSubBytes stage of the streaming inverse cipher.

## Interface
- INVERSE, 1, 1 selects InvShiftRows; 0 selects forward ShiftRows, so the encrypt path can reuse the block.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear; same effect as reset, taken on the next edge.
- in_valid  in  1  input byte valid.
- in_ready  out  1  block can accept an input byte.
- in_data  in  8  input state byte.
- out_valid  out  1  output byte valid.
- out_ready  in  1  downstream accepts the output byte.
- out_data  out  8  permuted state byte.
- out_last  out  1  high with the 16th output byte of a state.
- busy  out  1  high while any bank holds data or a partial state is being written.

## Operation
- Byte index k = r + 4c, with r = row 0..3 and c = column 0..3. Input bytes arrive in k order 0..15, and output bytes leave in k order 0..15.
- Permutation when INVERSE=1: out[r][c] = in[r][(c − r) mod 4]. When INVERSE=0: out[r][c] = in[r][(c + r) mod 4]. All column arithmetic is 2-bit and wraps naturally.
- Storage: bank0 and bank1, each 16×8 bits. Each bank has a full flag.
- Write side:
  - Pointer wbank and 4-bit counter wcnt.
  - in_ready = ~full[wbank].
  - Each accepted byte (in_valid & in_ready) is stored at bank[wbank][wcnt] and increments wcnt.
  - On acceptance with wcnt = 15: set full[wbank], toggle wbank, and wrap wcnt to 0.
- Read side:
  - Pointer rbank and 4-bit counter rcnt.
  - out_valid = full[rbank].
  - out_data = bank[rbank][src(rcnt)], where src maps the output index to the input index per the permutation above.
  - out_last = out_valid & (rcnt == 15).
  - Each transfer (out_valid & out_ready) increments rcnt.
  - On transfer with rcnt = 15: clear full[rbank], toggle rbank, and wrap rcnt to 0.
- Per-bank flag states are EMPTY → FILLING (write pointer on it, wcnt > 0) → FULL → DRAINING → EMPTY. Only the transitions above exist.
- Simultaneous events:
  - A write to one bank and a read from the other in the same cycle are independent.
  - A final write into a bank and a final read from the other bank in the same cycle set one flag and clear the other on the same edge.
- Backpressure:
  - out_valid and out_data hold stable while out_ready = 0.
  - in_data is ignored when in_ready = 0.
  - in_ready has no combinational path from out_ready. It depends only on registered flags.
- Reset or flush:
  - wbank, rbank, wcnt, rcnt and both full flags clear to 0.
  - A partial or undrained state is discarded. Bank contents need not be cleared.
  - After reset: in_ready=1, out_valid=0, out_last=0, busy=0. out_data is don't-care while out_valid=0.
- busy = full[0] | full[1] | (wcnt != 0).

## Timing
- Latency: if the 16th byte of a state is accepted at edge t, out_valid is high from just after t. The first output byte can transfer at edge t+1.
- Throughput: 1 byte/cycle sustained with out_ready held high. A continuous input stream never drops in_ready.
- With both banks full, in_ready = 0. It rises in the cycle after the edge that transfers the 16th byte of rbank.
- flush has priority over any concurrent handshake in the same cycle; that transfer is lost.
- rst_n deassertion is used as-is; synchronising it is the top level's responsibility.

## Test plan
- INVERSE=1, input bytes 0x00..0x0F, out_ready=1 -> output 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03. out_last is high only on 0x03. The first output appears the cycle after the 16th input.
- INVERSE=0, same input -> output 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B.
- Three back-to-back states, out_ready=1 -> in_ready stays 1 throughout, there are 48 contiguous output bytes, and each state is permuted correctly.
- out_ready=0 while 32 bytes are sent -> in_ready falls after byte 32. Raising out_ready drains 16 bytes, and in_ready returns the cycle after the 16th drained byte. out_data is stable while stalled.
- Random in_valid/out_ready toggling over 100 states -> the output matches the reference permutation model, with no lost or duplicated bytes.
- Assert rst_n low mid-state (after 7 input bytes), then separately pulse flush during draining -> all outputs reach their reset values. The next full state is emitted correctly with no residue from the aborted one.
